// File: rtl/gpio_config_loader.sv
// GPIO configuration loader: after a start request, clears the pad control
// shift chain, shifts one configuration word per pad (pad NPADS-1 first,
// MSB first), then pulses the chain's parallel-load strobe.
module gpio_config_loader #(
  parameter int unsigned NPADS    = 19,
  parameter int unsigned CFG_BITS = 13,
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned AW       = (NPADS > 1) ? $clog2(NPADS) : 1
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  output logic [AW-1:0]       cfg_addr,
  input  logic [CFG_BITS-1:0] cfg_data,
  output logic                busy,
  output logic                done,
  output logic                serial_clock,
  output logic                serial_data,
  output logic                serial_load,
  output logic                serial_resetn
);

  localparam int unsigned TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
  localparam logic [TW-1:0] TimerMax = TW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BitMax   = BW'(CFG_BITS - 1);
  localparam logic [AW-1:0] PadMax   = AW'(NPADS - 1);

  typedef enum logic [2:0] {StIdle, StClr, StShift, StLoad, StFin} state_e;

  state_e              state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                half_q, half_d;   // second half of the current two-phase slot
  logic [BW-1:0]       bit_q, bit_d;
  logic [AW-1:0]       pad_q, pad_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [CFG_BITS-1:0] shreg_q, shreg_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                sclk_q, sclk_d;
  logic                sdat_q, sdat_d;
  logic                sload_q, sload_d;
  logic                srstn_q, srstn_d;

  logic                tick;
  logic [AW-1:0]       addr_dec;
  logic [CFG_BITS-1:0] shreg_shift;

  assign tick        = (timer_q == TimerMax);
  assign addr_dec    = (addr_q == '0) ? '0 : addr_q - 1'b1;
  assign shreg_shift = shreg_q << 1;

  // Next-state logic: sequence control, timer, counters and registered outputs
  always_comb begin
    state_d = state_q;
    timer_d = tick ? '0 : timer_q + 1'b1;
    half_d  = half_q;
    bit_d   = bit_q;
    pad_d   = pad_q;
    addr_d  = addr_q;
    shreg_d = shreg_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sclk_d  = sclk_q;
    sdat_d  = sdat_q;
    sload_d = sload_q;
    srstn_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        half_d  = 1'b0;
        addr_d  = PadMax;
        if (start) begin
          state_d = StClr;
          busy_d  = 1'b1;
          srstn_d = 1'b0;
        end
      end
      StClr: begin
        srstn_d = 1'b0;
        if (tick) begin
          half_d = ~half_q;
          if (half_q) begin
            // Leave the clear phase by presenting the MSB of the first word
            state_d = StShift;
            srstn_d = 1'b1;
            half_d  = 1'b0;
            pad_d   = PadMax;
            bit_d   = BitMax;
            shreg_d = cfg_data;
            sdat_d  = cfg_data[CFG_BITS-1];
            addr_d  = addr_dec;
          end
        end
      end
      StShift: begin
        if (tick) begin
          if (!half_q) begin
            half_d = 1'b1;
            sclk_d = 1'b1;
          end else begin
            half_d = 1'b0;
            sclk_d = 1'b0;
            if (bit_q != '0) begin
              bit_d   = bit_q - 1'b1;
              shreg_d = shreg_shift;
              sdat_d  = shreg_shift[CFG_BITS-1];
            end else if (pad_q != '0) begin
              pad_d   = pad_q - 1'b1;
              bit_d   = BitMax;
              shreg_d = cfg_data;
              sdat_d  = cfg_data[CFG_BITS-1];
              addr_d  = addr_dec;
            end else begin
              state_d = StLoad;
              sdat_d  = 1'b0;
              sload_d = 1'b1;
            end
          end
        end
      end
      StLoad: begin
        if (tick) begin
          half_d = ~half_q;
          if (!half_q) begin
            sload_d = 1'b0;
          end else begin
            state_d = StFin;
            half_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      StFin: begin
        state_d = StIdle;
        addr_d  = PadMax;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register; every output is taken straight from a flop
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      timer_q <= '0;
      half_q  <= 1'b0;
      bit_q   <= '0;
      pad_q   <= '0;
      addr_q  <= PadMax;
      shreg_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      sdat_q  <= 1'b0;
      sload_q <= 1'b0;
      srstn_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      half_q  <= half_d;
      bit_q   <= bit_d;
      pad_q   <= pad_d;
      addr_q  <= addr_d;
      shreg_q <= shreg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sclk_q  <= sclk_d;
      sdat_q  <= sdat_d;
      sload_q <= sload_d;
      srstn_q <= srstn_d;
    end
  end

  assign cfg_addr      = addr_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign serial_clock  = sclk_q;
  assign serial_data   = sdat_q;
  assign serial_load   = sload_q;
  assign serial_resetn = srstn_q;

endmodule

// File: tb/tb_gpio_config_loader.sv
// Directed bench: three loader instances (default, 2x3 div1, 1x1 div3), each
// with a negedge monitor that models the serial chain and counts phases.
module tb_gpio_config_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  // ---------------- instance A: defaults 19 x 13, CLK_DIV 2 ----------------
  logic        a_rstn = 1'b1, a_start = 1'b0;
  logic [4:0]  a_addr;
  logic [12:0] a_data;
  logic        a_busy, a_done, a_sclk, a_sdat, a_sload, a_srstn;
  logic [12:0] a_tbl [19];

  always_comb a_data = (a_addr < 5'd19) ? a_tbl[a_addr] : 13'h0;

  gpio_config_loader u_a (
    .clock(clk), .resetn(a_rstn), .start(a_start), .cfg_addr(a_addr), .cfg_data(a_data),
    .busy(a_busy), .done(a_done), .serial_clock(a_sclk), .serial_data(a_sdat),
    .serial_load(a_sload), .serial_resetn(a_srstn)
  );

  int unsigned a_busy_n = 0, a_done_n = 0, a_rise_n = 0, a_load_n = 0, a_clr_n = 0;
  int unsigned a_hold_bad = 0, a_ovl = 0;
  logic        a_sclk_p = 1'b0, a_sdat_p = 1'b0;
  logic [246:0] a_chain = '0;

  always @(negedge clk) begin
    if (a_busy) a_busy_n++;
    if (a_done) a_done_n++;
    if (a_sload) a_load_n++;
    if (a_busy && !a_srstn) a_clr_n++;
    if (a_busy && a_done) a_ovl++;
    if (a_sclk && !a_sclk_p) begin
      a_rise_n++;
      a_chain = {a_chain[245:0], a_sdat};
    end
    if (a_sclk && a_sclk_p && (a_sdat != a_sdat_p)) a_hold_bad++;
    a_sclk_p = a_sclk;
    a_sdat_p = a_sdat;
  end

  // ---------------- instance B: 2 pads x 3 bits, CLK_DIV 1 ----------------
  logic       bc_rstn = 1'b1, b_start = 1'b0, c_start = 1'b0;
  logic [0:0] b_addr;
  logic [2:0] b_data;
  logic       b_busy, b_done, b_sclk, b_sdat, b_sload, b_srstn;

  always_comb b_data = (b_addr == 1'b1) ? 3'b101 : 3'b011;

  gpio_config_loader #(.NPADS(2), .CFG_BITS(3), .CLK_DIV(1)) u_b (
    .clock(clk), .resetn(bc_rstn), .start(b_start), .cfg_addr(b_addr), .cfg_data(b_data),
    .busy(b_busy), .done(b_done), .serial_clock(b_sclk), .serial_data(b_sdat),
    .serial_load(b_sload), .serial_resetn(b_srstn)
  );

  int unsigned b_busy_n = 0, b_done_n = 0, b_rise_n = 0, b_load_n = 0, b_clr_n = 0, b_ovl = 0;
  logic        b_sclk_p = 1'b0;
  logic [5:0]  b_chain = '0;

  always @(negedge clk) begin
    if (b_busy) b_busy_n++;
    if (b_done) b_done_n++;
    if (b_sload) b_load_n++;
    if (b_busy && !b_srstn) b_clr_n++;
    if (b_busy && b_done) b_ovl++;
    if (b_sclk && !b_sclk_p) begin
      b_rise_n++;
      b_chain = {b_chain[4:0], b_sdat};
    end
    b_sclk_p = b_sclk;
  end

  // ---------------- instance C: 1 pad x 1 bit, CLK_DIV 3 ----------------
  logic [0:0] c_addr;
  logic [0:0] c_data;
  logic       c_busy, c_done, c_sclk, c_sdat, c_sload, c_srstn;

  assign c_data = 1'b1;

  gpio_config_loader #(.NPADS(1), .CFG_BITS(1), .CLK_DIV(3)) u_c (
    .clock(clk), .resetn(bc_rstn), .start(c_start), .cfg_addr(c_addr), .cfg_data(c_data),
    .busy(c_busy), .done(c_done), .serial_clock(c_sclk), .serial_data(c_sdat),
    .serial_load(c_sload), .serial_resetn(c_srstn)
  );

  int unsigned c_busy_n = 0, c_rise_n = 0, c_hold_bad = 0, c_hi_run = 0, c_hi_len = 0;
  int unsigned c_lo_n = 0, c_load_n = 0, c_clr_n = 0;
  logic        c_sclk_p = 1'b0, c_sdat_p = 1'b0, c_bit = 1'b0;

  always @(negedge clk) begin
    if (c_busy) c_busy_n++;
    if (c_sload) c_load_n++;
    if (c_busy && !c_srstn) c_clr_n++;
    if (c_sdat && !c_sclk) c_lo_n++;
    if (c_sclk && !c_sclk_p) begin
      c_rise_n++;
      c_bit = c_sdat;
    end
    if (c_sclk && c_sclk_p && (c_sdat != c_sdat_p)) c_hold_bad++;
    if (c_sclk) c_hi_run++;
    else if (c_sclk_p) begin
      c_hi_len = c_hi_run;
      c_hi_run = 0;
    end
    c_sclk_p = c_sclk;
    c_sdat_p = c_sdat;
  end

  // ---------------- helpers for instance A ----------------
  task automatic a_wait_done(input string tag);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (a_done) break;
    end
    check(tag, a_done, 1'b1);
  endtask

  task automatic a_full_run();
    int unsigned b0, d0, r0, l0, c0;
    b0 = a_busy_n; d0 = a_done_n; r0 = a_rise_n; l0 = a_load_n; c0 = a_clr_n;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    check("a_busy_rise", a_busy, 1'b1);
    check("a_addr_first", a_addr, 5'd18);
    a_wait_done("a_done_seen");
    check("a_busy_at_done", a_busy, 1'b0);
    @(negedge clk);
    check("a_busy_cycles", a_busy_n - b0, 996);
    check("a_sclk_rises", a_rise_n - r0, 247);
    check("a_done_count", a_done_n - d0, 1);
    check("a_load_cycles", a_load_n - l0, 2);
    check("a_clr_cycles", a_clr_n - c0, 4);
    check("a_addr_idle", a_addr, 5'd18);
    for (int p = 0; p < 19; p++) check("a_chain_pad", a_chain[p*13 +: 13], a_tbl[p]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int unsigned b0, d0;
    for (int p = 0; p < 19; p++) a_tbl[p] = 13'($urandom);
    a_tbl[18] = 13'h1abc;
    a_tbl[0]  = 13'h0f0f;

    // Test 1: reset values, then release
    #1;
    a_rstn  = 1'b0;
    bc_rstn = 1'b0;
    #2;
    check("rst_busy", a_busy, 1'b0);
    check("rst_done", a_done, 1'b0);
    check("rst_sclk", a_sclk, 1'b0);
    check("rst_sdat", a_sdat, 1'b0);
    check("rst_sload", a_sload, 1'b0);
    check("rst_srstn", a_srstn, 1'b0);
    check("rst_addr", a_addr, 5'd18);
    @(negedge clk);
    a_rstn  = 1'b1;
    bc_rstn = 1'b1;
    @(posedge clk);
    #1;
    check("rel_srstn", a_srstn, 1'b1);
    check("rel_busy", a_busy, 1'b0);
    check("rel_sclk", a_sclk, 1'b0);
    check("rel_sload", a_sload, 1'b0);
    check("rel_done", a_done, 1'b0);
    check("rel_b_srstn", b_srstn, 1'b1);

    // Test 2: small chain, bits 101 then 011
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (b_done) break;
    end
    check("b_done_seen", b_done, 1'b1);
    check("b_busy_at_done", b_busy, 1'b0);
    @(negedge clk);
    check("b_busy_cycles", b_busy_n, 16);
    check("b_clr_cycles", b_clr_n, 2);
    check("b_sclk_rises", b_rise_n, 6);
    check("b_bits", b_chain, 6'b101011);
    check("b_load_cycles", b_load_n, 1);
    check("b_done_count", b_done_n, 1);
    check("b_overlap", b_ovl, 0);

    // Test 6: CLK_DIV 3, single bit
    c_start = 1'b1;
    @(negedge clk);
    c_start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (c_done) break;
    end
    check("c_done_seen", c_done, 1'b1);
    @(negedge clk);
    check("c_busy_cycles", c_busy_n, 18);
    check("c_hi_len", c_hi_len, 3);
    check("c_lo_len", c_lo_n, 3);
    check("c_hold", c_hold_bad, 0);
    check("c_rises", c_rise_n, 1);
    check("c_bit", c_bit, 1'b1);
    check("c_load_cycles", c_load_n, 3);
    check("c_clr_cycles", c_clr_n, 6);

    // Test 3: full default-size load
    a_full_run();

    // Test 4: held start, starts during SHIFT and in FIN are ignored
    b0 = a_busy_n; d0 = a_done_n;
    a_start = 1'b1;
    repeat (5) @(negedge clk);
    a_start = 1'b0;
    repeat (100) @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (300) @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    a_wait_done("a_held_done");
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (2) @(negedge clk);
    check("a_fin_start_ignored", a_busy, 1'b0);
    check("a_held_busy_cycles", a_busy_n - b0, 996);
    check("a_held_done_count", a_done_n - d0, 1);

    // Start in the IDLE cycle right after FIN is accepted
    b0 = a_busy_n; d0 = a_done_n;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    a_wait_done("a_seq1_done");
    @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    check("a_restart_busy", a_busy, 1'b1);
    a_wait_done("a_seq2_done");
    @(negedge clk);
    check("a_back2back_done", a_done_n - d0, 2);
    check("a_back2back_busy", a_busy_n - b0, 1992);
    check("a_overlap", a_ovl, 0);
    check("a_hold", a_hold_bad, 0);

    // Test 5: abort in the middle of SHIFT, then a clean run
    d0 = a_done_n;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (500) @(negedge clk);
    check("abort_mid_busy", a_busy, 1'b1);
    a_rstn = 1'b0;
    #1;
    check("abort_busy", a_busy, 1'b0);
    check("abort_sclk", a_sclk, 1'b0);
    check("abort_sdat", a_sdat, 1'b0);
    check("abort_srstn", a_srstn, 1'b0);
    check("abort_addr", a_addr, 5'd18);
    @(negedge clk);
    a_rstn = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_idle", a_busy, 1'b0);
    check("abort_srstn_up", a_srstn, 1'b1);
    check("abort_no_done", a_done_n - d0, 0);
    a_full_run();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
